// File: rtl/pong_pkg.sv
// Shared pong definitions: position width, playfield constants and the
// computer-paddle FSM state encoding.
//   POS_W          : width of every Y coordinate
//   CENTER_YPOS    : rest position for a paddle when the ball recedes
//   SCREEN_TOP/BOT : vertical limits enforced by the paddle-movement block
package pong_pkg;

  localparam int POS_W = 10;

  localparam logic [POS_W-1:0] CENTER_YPOS   = 10'd220;
  localparam logic [POS_W-1:0] SCREEN_TOP    = 10'd21;
  localparam logic [POS_W-1:0] SCREEN_BOTTOM = 10'd459;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT      = 2'd1;
  localparam logic [1:0] ST_MOVE_UP   = 2'd2;
  localparam logic [1:0] ST_MOVE_DOWN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_WAIT      = ST_WAIT,
    S_MOVE_UP   = ST_MOVE_UP,
    S_MOVE_DOWN = ST_MOVE_DOWN
  } paddle_state_t;

  // Magnitude of an (POS_W+1)-bit two's complement error. The error is a
  // difference of two zero-extended positions, so it never reaches the most
  // negative code and the negation cannot wrap.
  function automatic logic [POS_W:0] err_mag(input logic [POS_W:0] e);
    return e[POS_W] ? (~e + 1'b1) : e;
  endfunction

endpackage

// File: rtl/cpu_paddle_driver_if.sv
// Position/command bundle between the game logic and the computer paddle
// driver.
//   inPlay       : 1 = game running
//   ballY        : ball centre Y
//   ballApproach : 1 = ball travelling toward this paddle
//   paddleY      : current paddle Y from the movement block
//   up / down    : movement requests back to the movement block
interface cpu_paddle_driver_if;
  import pong_pkg::*;

  logic             inPlay;
  logic [POS_W-1:0] ballY;
  logic             ballApproach;
  logic [POS_W-1:0] paddleY;
  logic             up;
  logic             down;

  modport master (
    output inPlay, ballY, ballApproach, paddleY,
    input  up, down
  );

  modport slave (
    input  inPlay, ballY, ballApproach, paddleY,
    output up, down
  );

endinterface

// File: rtl/reaction_timer.sv
// Loadable down-counter that paces the opponent's reaction.
//   clock, reset : system clock, synchronous active-high reset
//   load         : load load_val (wins over dec)
//   clear        : force the count to zero
//   dec          : decrement by one, saturating at zero
//   load_val     : value taken on load
//   zero         : count is zero
module reaction_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/cpu_paddle_driver.sv
// Computer opponent for the right-hand paddle. Chases the ball Y while the
// ball approaches, returns to the screen centre while it recedes, and only
// starts a move after the error has stayed outside a deadband for a
// reaction delay.
//   clock, reset : system clock, synchronous active-high reset
//   pif          : slave side of cpu_paddle_driver_if (positions in,
//                  registered up/down requests out)
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_IDLE     | on target (within deadband) or just finished a move
// S_WAIT     | error outside deadband, reaction delay running
// S_MOVE_UP  | requesting paddle Y decrement until target reached
// S_MOVE_DOWN| requesting paddle Y increment until target reached
module cpu_paddle_driver
  import pong_pkg::*;
#(
  parameter logic [POS_W-1:0] CENTER_YPOS = pong_pkg::CENTER_YPOS,
  parameter logic [POS_W-1:0] DEADBAND    = 10'd8,
  parameter logic [7:0]       REACT_DELAY = 8'd20
) (
  input logic                clock,
  input logic                reset,
  cpu_paddle_driver_if.slave pif
);

  paddle_state_t state, state_next;

  logic [POS_W-1:0] target;
  logic [POS_W:0]   err;
  logic [POS_W:0]   err_abs;
  logic             outside_band;
  logic             err_neg;
  logic             err_pos;

  logic timer_load;
  logic timer_dec;
  logic timer_clear;
  logic timer_zero;

  logic up_q;
  logic down_q;

  assign target       = pif.ballApproach ? pif.ballY : CENTER_YPOS;
  assign err          = {1'b0, target} - {1'b0, pif.paddleY};
  assign err_abs      = err_mag(err);
  assign outside_band = (err_abs > {1'b0, DEADBAND});
  assign err_neg      = err[POS_W];
  assign err_pos      = !err[POS_W] && (err != '0);

  // Pausing wipes any pending reaction so play resumes with a full delay.
  assign timer_clear  = !pif.inPlay;

  reaction_timer #(
    .WIDTH (8)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (timer_load),
    .clear    (timer_clear),
    .dec      (timer_dec),
    .load_val (REACT_DELAY - 8'd1),
    .zero     (timer_zero)
  );

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (outside_band) begin
          state_next = S_WAIT;
          timer_load = 1'b1;
        end
      end
      S_WAIT: begin
        if (!outside_band) begin
          state_next = S_IDLE;
        end else if (timer_zero) begin
          state_next = err_neg ? S_MOVE_UP : S_MOVE_DOWN;
        end else begin
          timer_dec = 1'b1;
        end
      end
      // A move always ends in IDLE, even when the target has jumped to the
      // other side; the reversal then pays the reaction delay again.
      S_MOVE_UP: begin
        if (!err_neg) begin
          state_next = S_IDLE;
        end
      end
      S_MOVE_DOWN: begin
        if (!err_pos) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (!pif.inPlay) begin
      state_next = S_IDLE;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
    end
  end

  // Outputs decode the next state so they switch on the same edge the FSM
  // enters or leaves a move.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      state  <= state_next;
      up_q   <= (state_next == S_MOVE_UP);
      down_q <= (state_next == S_MOVE_DOWN);
    end
  end

  assign pif.up   = up_q;
  assign pif.down = down_q;

endmodule

// File: doc/cpu_paddle_driver.md
# cpu_paddle_driver

Computer-opponent key generator for the right-hand paddle. It watches ball and paddle Y positions and drives `up`/`down` commands into a paddle-movement block, in place of the player's keys. The target is the ball Y while the ball approaches and the screen centre while it recedes. A deadband and a reaction delay keep the opponent beatable.

## Interface
Parameters:
- `CENTER_YPOS`, default 10'd220: rest target while the ball moves away.
- `DEADBAND`, default 10'd8: no move is started while |target − paddleY| ≤ DEADBAND.
- `REACT_DELAY`, default 8'd20: cycles the error must persist before a move starts. Legal range is ≥1.

Ports:
- `clock`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high.
- `inPlay`, in, 1: 1 = game running, 0 = paused.
- `ballY`, in, 10: ball centre Y, in pixels.
- `ballApproach`, in, 1: 1 = ball travelling toward this paddle.
- `paddleY`, in, 10: current paddle Y, fed back from the movement block.
- `up`, out, 1: registered; request paddle Y to decrement.
- `down`, out, 1: registered; request paddle Y to increment.

## Operation
- `target` = `ballApproach` ? `ballY` : `CENTER_YPOS`.
- `err` = {1'b0,target} − {1'b0,paddleY}.
  - 11-bit two's complement.
  - `err` < 0 means the paddle is below the target, so it must move up.
  - |err| is computed on 11 bits, with no wrap.
- FSM states: IDLE, WAIT, MOVE_UP, MOVE_DOWN.
- IDLE:
  - Outputs are 0.
  - If |err| > DEADBAND: go to WAIT and load `delayCnt` = REACT_DELAY−1.
- WAIT:
  - Outputs are 0.
  - If |err| ≤ DEADBAND: return to IDLE. The error has vanished, so the move is abandoned.
  - Else if `delayCnt` == 0: go to MOVE_UP if err < 0, otherwise MOVE_DOWN.
  - Else: decrement `delayCnt`.
- MOVE_UP:
  - `up` = 1.
  - Go to IDLE when err ≥ 0 (paddle has reached or passed the target).
- MOVE_DOWN:
  - `down` = 1.
  - Go to IDLE when err ≤ 0.
- Target jumps mid-move (for example, `ballApproach` toggles):
  - There is no direct MOVE_UP↔MOVE_DOWN transition.
  - The FSM exits through IDLE and pays the full reaction delay again.
- `inPlay` = 0:
  - The next edge forces IDLE, clears `delayCnt`, and drives `up` = `down` = 0.
  - This has priority over all transitions except reset.
- Invariant: `up` & `down` is never 1.
- Clamping at the screen edges belongs to the paddle-movement block. This block may keep requesting motion at a limit.

## Timing
- Reset, on a synchronous edge: state = IDLE, `delayCnt` = 0, `up` = 0, `down` = 0.
  - Reset mid-move drops the outputs on that same edge.
- `up`/`down` are registered from the next-state decode, so they change on the same edge the FSM enters or leaves a MOVE state.
- Latency from the edge where |err| first exceeds DEADBAND to `up`/`down` high is REACT_DELAY+1 edges:
  - 1 edge for IDLE→WAIT.
  - REACT_DELAY edges in WAIT.
- Minimum gap between two moves is REACT_DELAY+1 cycles with outputs low.
- The paddle block moves 1 px per cycle, so a move of N px stays asserted for about N cycles. The MOVE exit test uses the live `paddleY`, which allows at most 1 px of overshoot.
- The inputs are sampled every cycle. They are the game-logic registers and need no synchroniser.

## Structure
Shared package `pong_pkg`:
- FSM state encoding (2-bit localparams).
- Position width, 10.
- `CENTER_YPOS` and the screen limits (21/459), shared with the paddle-movement block.

One sub-module, `reaction_timer`, holds the loadable down-counter with `load`, `clear` and `zero` signals. The FSM and the error arithmetic stay in the top module.

## Test plan
- Reset with paddleY=220, ballY=300, approach=1, inPlay=1:
  - `up`=`down`=0 during reset.
  - After release, `down` rises exactly 21 edges later.
  - `down` falls on the edge after paddleY reaches 300.
- Deadband:
  - paddleY=220, ballY=228: outputs stay 0 indefinitely.
  - ballY=229: `down` asserts after 21 edges.
- Abandoned wait: paddleY=220, ballY=250; drop ballY to 225 at cycle 10 of WAIT → the FSM returns to IDLE and no output pulses.
- Recentre:
  - ballApproach=0, paddleY=400: `up` asserts after the delay and deasserts when paddleY ≤ 220.
  - Toggling approach mid-move goes through IDLE with a fresh delay, and `up`/`down` are never high together.
- Pause: inPlay→0 during MOVE_DOWN drops `down` on the next edge. inPlay→1 restarts from IDLE with the full delay.
- Synchronous reset asserted mid-MOVE_UP: `up`=0 on that edge. Reset asserted between edges has no effect until the next edge.
